// File: rtl/sdram_ch8_bridge_if.sv
// Request/response and controller-channel signals of one 8-bit SDRAM bridge.
// The slave modport is the bridge side; master is the CPU/controller side.
interface sdram_ch8_bridge_if;
   logic        req_valid;
   logic        req_we;
   logic [24:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        idle;
   logic [24:0] ch_addr;
   logic        ch_rd;
   logic        ch_wr;
   logic [7:0]  ch_din;
   logic [7:0]  ch_dout;
   logic        ch_busy;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, ch_dout, ch_busy,
      output req_ready, rsp_valid, rsp_rdata, idle, ch_addr, ch_rd, ch_wr, ch_din
   );
   modport master (
      output req_valid, req_we, req_addr, req_wdata, ch_dout, ch_busy,
      input  req_ready, rsp_valid, rsp_rdata, idle, ch_addr, ch_rd, ch_wr, ch_din
   );
endinterface

// File: rtl/sdram_ch8_bridge.sv
// Valid/ready to strobe+busy bridge for one 8-bit SDRAM controller channel.
// Writes are posted in a FIFO; a read waits until the FIFO has drained.
module sdram_ch8_bridge #(
   parameter int FIFO_AW = 2
) (
   input logic clk,
   input logic reset,
   sdram_ch8_bridge_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_e;

   state_e            state_q, state_d;
   logic [FIFO_AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [24:0]       fifo_addr_q [DEPTH];
   logic [7:0]        fifo_data_q [DEPTH];
   logic              rd_pend_q, rd_pend_d;
   logic [24:0]       rd_addr_q, rd_addr_d;
   logic              op_wr_q, op_wr_d;
   logic              alive_q;
   logic [24:0]       ch_addr_q, ch_addr_d;
   logic [7:0]        ch_din_q, ch_din_d;
   logic              ch_rd_q, ch_rd_d, ch_wr_q, ch_wr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_rdata_q, rsp_rdata_d;
   logic              idle_q, idle_d;
   logic              full, empty, req_ready, push, rd_acc;

   assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   // alive_q keeps ready low while reset is asserted
   assign req_ready = alive_q & ~rd_pend_q & (~bus.req_we | ~full);
   assign push      = bus.req_valid & req_ready & bus.req_we;
   assign rd_acc    = bus.req_valid & req_ready & ~bus.req_we;

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.idle      = idle_q;
   assign bus.ch_addr   = ch_addr_q;
   assign bus.ch_din    = ch_din_q;
   assign bus.ch_rd     = ch_rd_q;
   assign bus.ch_wr     = ch_wr_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wptr_q[FIFO_AW-1:0]] <= bus.req_addr;
         fifo_data_q[wptr_q[FIFO_AW-1:0]] <= bus.req_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         rd_pend_q   <= 1'b0;
         rd_addr_q   <= '0;
         op_wr_q     <= 1'b0;
         alive_q     <= 1'b0;
         ch_addr_q   <= '0;
         ch_din_q    <= '0;
         ch_rd_q     <= 1'b0;
         ch_wr_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         idle_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         rd_pend_q   <= rd_pend_d;
         rd_addr_q   <= rd_addr_d;
         op_wr_q     <= op_wr_d;
         alive_q     <= 1'b1;
         ch_addr_q   <= ch_addr_d;
         ch_din_q    <= ch_din_d;
         ch_rd_q     <= ch_rd_d;
         ch_wr_q     <= ch_wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         idle_q      <= idle_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wptr_d      = push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d      = rptr_q;
      rd_pend_d   = rd_pend_q;
      rd_addr_d   = rd_addr_q;
      op_wr_d     = op_wr_q;
      ch_addr_d   = ch_addr_q;
      ch_din_d    = ch_din_q;
      ch_rd_d     = ch_rd_q;
      ch_wr_d     = ch_wr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      if (rd_acc) begin
         rd_pend_d = 1'b1;
         rd_addr_d = bus.req_addr;
      end

      case (state_q)
         // busy here may be a stale access that survived a reset
         S_IDLE: begin
            if (!bus.ch_busy) begin
               if (!empty) begin
                  ch_addr_d = fifo_addr_q[rptr_q[FIFO_AW-1:0]];
                  ch_din_d  = fifo_data_q[rptr_q[FIFO_AW-1:0]];
                  ch_wr_d   = 1'b1;
                  op_wr_d   = 1'b1;
                  state_d   = S_STROBE;
               end else if (rd_pend_q) begin
                  ch_addr_d = rd_addr_q;
                  ch_rd_d   = 1'b1;
                  op_wr_d   = 1'b0;
                  state_d   = S_STROBE;
               end
            end
         end
         S_STROBE: begin
            if (bus.ch_busy) begin
               ch_rd_d = 1'b0;
               ch_wr_d = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.ch_busy) begin
               if (op_wr_q) begin
                  rptr_d = rptr_q + PTR_ONE;
               end else begin
                  rsp_rdata_d = bus.ch_dout;
                  rsp_valid_d = 1'b1;
                  rd_pend_d   = 1'b0;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      idle_d = (wptr_d == rptr_d) & ~rd_pend_d & (state_d == S_IDLE) & ~bus.ch_busy;
   end
endmodule
